// File: rtl/uart_recv_if.sv
// uart_recv_if: serial-pin and byte-output bundle for the UART receiver.
// The slave modport is the receiver's view; the master modport is the view of
// whoever drives the pin and consumes the received bytes.
interface uart_recv_if;
   logic       rxd;          // serial line, idle high, asynchronous to clk
   logic [7:0] data;         // last correctly received byte
   logic       data_valid;   // one-cycle strobe: data updated this cycle
   logic       frame_err;    // one-cycle strobe: stop bit sampled low
   logic       parity_err;   // one-cycle strobe: parity mismatch
   logic       idle;         // high when no frame is in progress

   modport master (
      output rxd,
      input  data,
      input  data_valid,
      input  frame_err,
      input  parity_err,
      input  idle
   );

   modport slave (
      input  rxd,
      output data,
      output data_valid,
      output frame_err,
      output parity_err,
      output idle
   );
endinterface

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver (8E1 when UART_RECV_PARITY_EN is defined).
// RXD is double-flopped, the start edge is confirmed at mid-bit, and every
// later bit is sampled one bit period after the previous sample point.
// The frame verdict is registered once more before it reaches the outputs,
// so DATA, DATA_VALID, FRAME_ERR and PARITY_ERR all leave from flops together.
// CLKS_PER_BIT must be at least 4.
// Optional feature macro: UART_RECV_PARITY_EN (even parity bit after the data).
module uart_recv #(
   parameter int CLKS_PER_BIT = 27,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic        clk,
   input  logic        rst,      // asynchronous, active-low
   uart_recv_if.slave  bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
`ifdef UART_RECV_PARITY_EN
      , S_PARITY = 3'd5
`endif
   } state_t;

`ifdef UART_RECV_PARITY_EN
   // Even parity: the XOR over data and parity bit is 1 when the frame is bad.
   function automatic logic parity_bad(input logic [7:0] d, input logic p);
      return (^d) ^ p;
   endfunction
`endif

   // synchroniser
   logic             rxd_meta_r;
   logic             rxd_sync_r;

   // frame engine
   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] clk_cnt_r;
   logic [CNT_W-1:0] clk_cnt_s;
   logic [2:0]       bit_cnt_r;
   logic [2:0]       bit_cnt_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_s;
   logic             idle_r;

   // frame verdict, one cycle ahead of the output strobes
   logic             pend_valid_r;
   logic             pend_valid_s;
   logic             pend_ferr_r;
   logic             pend_ferr_s;

   // output registers
   logic [7:0]       data_r;
   logic             data_valid_r;
   logic             frame_err_r;

`ifdef UART_RECV_PARITY_EN
   logic             par_bit_r;
   logic             par_bit_s;
   logic             pend_perr_r;
   logic             pend_perr_s;
   logic             parity_err_r;
`endif

   // Bring the asynchronous serial line into the clk domain (idle level on reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta_r <= 1'b1;
         rxd_sync_r <= 1'b1;
      end else begin
         rxd_meta_r <= bus.rxd;
         rxd_sync_r <= rxd_meta_r;
      end
   end

   // Next-state, counter and shift logic; decisions use only the synchronised line.
   always_comb begin
      state_s      = state_r;
      clk_cnt_s    = clk_cnt_r + CNT_W'(1);
      bit_cnt_s    = bit_cnt_r;
      shift_s      = shift_r;
      pend_valid_s = 1'b0;
      pend_ferr_s  = 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_bit_s    = par_bit_r;
      pend_perr_s  = 1'b0;
`endif
      case (state_r)
         S_IDLE: begin
            clk_cnt_s = '0;
            if (!rxd_sync_r) begin
               state_s = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end

         S_START: begin
            if (clk_cnt_r == HALF_LAST) begin
               clk_cnt_s = '0;
               if (rxd_sync_r) begin
                  // line went back high before mid-bit: a glitch, not a start bit
                  state_s = S_IDLE;
               end else begin
                  state_s   = S_DATA;
                  bit_cnt_s = 3'd0;
               end
            end else begin
               state_s = S_START;
            end
         end

         S_DATA: begin
            if (clk_cnt_r == BIT_LAST) begin
               clk_cnt_s = '0;
               shift_s   = {rxd_sync_r, shift_r[7:1]};
               bit_cnt_s = bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
                  state_s = S_PARITY;
`else
                  state_s = S_STOP;
`endif
               end else begin
                  state_s = S_DATA;
               end
            end else begin
               state_s = S_DATA;
            end
         end

`ifdef UART_RECV_PARITY_EN
         S_PARITY: begin
            if (clk_cnt_r == BIT_LAST) begin
               clk_cnt_s = '0;
               par_bit_s = rxd_sync_r;
               state_s   = S_STOP;
            end else begin
               state_s = S_PARITY;
            end
         end
`endif

         S_STOP: begin
            if (clk_cnt_r == BIT_LAST) begin
               clk_cnt_s = '0;
               if (rxd_sync_r) begin
                  // leaving at mid-stop leaves half a bit to catch a back-to-back start
                  state_s = S_IDLE;
`ifdef UART_RECV_PARITY_EN
                  if (parity_bad(shift_r, par_bit_r)) begin
                     pend_perr_s = 1'b1;
                  end else begin
                     pend_valid_s = 1'b1;
                  end
`else
                  pend_valid_s = 1'b1;
`endif
               end else begin
                  // a bad stop bit wins over any parity result
                  pend_ferr_s = 1'b1;
                  state_s     = S_BREAK;
               end
            end else begin
               state_s = S_STOP;
            end
         end

         S_BREAK: begin
            clk_cnt_s = '0;
            if (rxd_sync_r) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_BREAK;
            end
         end

         default: begin
            state_s   = S_IDLE;
            clk_cnt_s = '0;
            bit_cnt_s = 3'd0;
         end
      endcase
   end

   // Frame engine state; reset aborts any frame and discards the partial byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= S_IDLE;
         clk_cnt_r    <= '0;
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         idle_r       <= 1'b1;
         pend_valid_r <= 1'b0;
         pend_ferr_r  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
         par_bit_r    <= 1'b0;
         pend_perr_r  <= 1'b0;
`endif
      end else begin
         state_r      <= state_s;
         clk_cnt_r    <= clk_cnt_s;
         bit_cnt_r    <= bit_cnt_s;
         shift_r      <= shift_s;
         idle_r       <= (state_s == S_IDLE);
         pend_valid_r <= pend_valid_s;
         pend_ferr_r  <= pend_ferr_s;
`ifdef UART_RECV_PARITY_EN
         par_bit_r    <= par_bit_s;
         pend_perr_r  <= pend_perr_s;
`endif
      end
   end

   // Output stage: publish the verdict as one-cycle strobes; DATA only moves on a good frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r       <= 8'h00;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         data_valid_r <= pend_valid_r;
         frame_err_r  <= pend_ferr_r;
`ifdef UART_RECV_PARITY_EN
         parity_err_r <= pend_perr_r;
`endif
         if (pend_valid_r) begin
            data_r <= shift_r;
         end else begin
            data_r <= data_r;
         end
      end
   end

   assign bus.data       = data_r;
   assign bus.data_valid = data_valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.idle       = idle_r;
`ifdef UART_RECV_PARITY_EN
   assign bus.parity_err = parity_err_r;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed bench for uart_recv. Frames are driven bit by bit;
// a frame-level model predicts which strobe appears and on which cycle, and a
// per-cycle compare process checks strobes and DATA against it.
module tb_uart_recv;

   localparam int CPB  = 27;
   localparam int HALF = CPB / 2;
`ifdef UART_RECV_PARITY_EN
   localparam int FRAME_BITS = 10;   // data + parity + stop after the start bit
   localparam int LAT_LIT    = 286;
`else
   localparam int FRAME_BITS = 9;    // data + stop after the start bit
   localparam int LAT_LIT    = 259;
`endif
   // cycles from the first edge that sees the start bit low to the strobe
   localparam int LAT = 2 + HALF + FRAME_BITS * CPB + 1;

   typedef enum int {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
   typedef struct {
      int         cyc;
      ev_kind_t   kind;
      logic [7:0] b;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   uart_recv_if bus();

   uart_recv #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   ev_t        q[$];
   logic [7:0] model_data = 8'h00;
   int         last_start = 0;
   int         last_dv_cyc = 0;
   int         n_dv = 0;
   int         n_ferr = 0;
   int         n_perr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // strobe counters and timestamp used by the hand checks
   always @(negedge clk) begin
      if (bus.data_valid === 1'b1) begin
         last_dv_cyc = cyc;
         n_dv++;
      end
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.parity_err === 1'b1) n_perr++;
   end

   // per-cycle compare against the frame-level model
   always @(negedge clk) begin
      logic ev_v, ev_f, ev_p;
      ev_t  e;
      ev_v = 1'b0;
      ev_f = 1'b0;
      ev_p = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         case (e.kind)
            EV_VALID: begin ev_v = 1'b1; model_data = e.b; end
            EV_FERR:  ev_f = 1'b1;
            EV_PERR:  ev_p = 1'b1;
            default:  ev_v = 1'b0;
         endcase
      end
      n_tests++;
      if ({bus.data_valid, bus.frame_err, bus.parity_err} !== {ev_v, ev_f, ev_p}
          || bus.data !== model_data) begin
         n_fail++;
         $display("FAIL cycle_check cyc=%0d: got dv/fe/pe=%b%b%b data=%h, required %b%b%b data=%h",
                  cyc, bus.data_valid, bus.frame_err, bus.parity_err, bus.data,
                  ev_v, ev_f, ev_p, model_data);
      end
      if (rst === 1'b0) begin
         n_tests++;
         if (bus.idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d: got %b, required 1", cyc, bus.idle);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive_bit(input logic v);
      bus.rxd = v;
      repeat (CPB) @(negedge clk);
   endtask

   // drive one frame starting at a negedge and predict its outcome
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      ev_t e;
      int  s;
      s = cyc + 1;
      last_start = s;
      e.cyc = s + LAT;
      e.b   = b;
      if (!stop_bit) begin
         e.kind = EV_FERR;
      end else begin
         e.kind = EV_VALID;
`ifdef UART_RECV_PARITY_EN
         if (((^b) ^ par_bit) == 1'b1) e.kind = EV_PERR;
`endif
      end
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RECV_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic enter_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      q.delete();
      model_data = 8'h00;
   endtask

   task automatic leave_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bus.rxd = 1'b1;
      rst     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_data", bus.data, 8'h00);
      chk("reset_idle_hand", bus.idle, 1);
      leave_reset();
      repeat (5) @(negedge clk);

      // single frame: value, latency and idle afterwards
      send_frame(8'hAA, 1'b1, ^(8'hAA));
      repeat (10) @(negedge clk);
      chk("aa_data", bus.data, 8'hAA);
      chk("aa_latency", last_dv_cyc - last_start, LAT_LIT);
      chk("aa_idle", bus.idle, 1);
      chk("aa_dv_count", n_dv, 1);

      // back-to-back frames with no idle gap
      send_frame(8'hAA, 1'b1, ^(8'hAA));
      send_frame(8'h4C, 1'b1, ^(8'h4C));
      repeat (10) @(negedge clk);
      chk("b2b_data", bus.data, 8'h4C);
      chk("b2b_latency", last_dv_cyc - last_start, LAT_LIT);
      chk("b2b_dv_count", n_dv, 3);
      repeat (20) @(negedge clk);

      // 5-cycle low glitch: IDLE drops for a while, then returns with no strobe
      bus.rxd = 1'b0;
      s = cyc + 1;
      repeat (5) @(negedge clk);
      bus.rxd = 1'b1;
      while (cyc < s + HALF + 1) @(negedge clk);
      chk("glitch_idle_low", bus.idle, 0);
      @(negedge clk);
      chk("glitch_idle_back", bus.idle, 1);
      repeat (40) @(negedge clk);
      chk("glitch_no_dv", n_dv, 3);
      chk("glitch_no_ferr", n_ferr, 0);

      // bad stop bit followed by a long break: one FRAME_ERR, DATA held
      send_frame(8'h55, 1'b0, ^(8'h55));
      repeat (500) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (30) @(negedge clk);
      chk("break_ferr_count", n_ferr, 1);
      chk("break_data_held", bus.data, 8'h4C);
      send_frame(8'h3C, 1'b1, ^(8'h3C));
      repeat (10) @(negedge clk);
      chk("after_break_data", bus.data, 8'h3C);

      // reset in the middle of data bit 4 of 0xFF, then a clean 0x12
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      repeat (HALF) @(negedge clk);
      enter_reset();
      repeat (5) @(negedge clk);
      chk("abort_data_reset", bus.data, 8'h00);
      leave_reset();
      repeat (5) @(negedge clk);
      send_frame(8'h12, 1'b1, ^(8'h12));
      repeat (10) @(negedge clk);
      chk("abort_then_data", bus.data, 8'h12);
      chk("abort_dv_count", n_dv, 5);

`ifdef UART_RECV_PARITY_EN
      // even parity: 0x07 needs parity 1
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("par_good_data", bus.data, 8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      chk("par_bad_data_held", bus.data, 8'h07);
      chk("par_bad_perr_count", n_perr, 1);
      chk("par_dv_count", n_dv, 6);
`else
      chk("no_parity_err", n_perr, 0);
`endif

      repeat (20) @(negedge clk);
      chk("model_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
